// File: rtl/hexuart_pkg.sv
// Shared constants, state types and hex-digit decode for the hex-line UART link.
// HEXUART_RX_LOWERCASE_EN: also accept 'a'-'f' as hex digits.
package hexuart_pkg;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_LA = 8'h61;

    localparam int HEX_DIGITS = 8;

    typedef enum logic [1:0] {
        S_PREFIX,
        S_HEX,
        S_LF,
        S_CR
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Returns {valid, nibble}.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= CH_0 && c <= CH_0 + 8'd9)
            r = {1'b1, 4'(c - CH_0)};
        else if (c >= CH_A && c <= CH_A + 8'd5)
            r = {1'b1, 4'(c - CH_A + 8'd10)};
`ifdef HEXUART_RX_LOWERCASE_EN
        else if (c >= CH_LA && c <= CH_LA + 8'd5)
            r = {1'b1, 4'(c - CH_LA + 8'd10)};
`endif
        return r;
    endfunction

endpackage

// File: rtl/hexuart_deserializer.sv
// 8N1 UART byte receiver with 2-FF input synchronizer.
// Returns to idle at mid-stop so back-to-back bytes decode.
module hexuart_deserializer
    import hexuart_pkg::*;
#(
    parameter int SAMPLECLK = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW   = $clog2(SAMPLECLK + 1);
    localparam int HALF = SAMPLECLK / 2;

    rx_state_t     state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rxs;

    assign rxs = sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RX_IDLE;
            sync       <= 2'b11;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rx};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rxs)
                        state <= RX_START;
                end
                RX_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(SAMPLECLK - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(SAMPLECLK - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rxs) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/hexuart_receiver.sv
// Hex-line UART receiver: parses <prefix><8 hex><LF><CR> into prefix/value.
// HEXUART_RX_LOWERCASE_EN: lowercase hex digits accepted (see hexuart_pkg).
module hexuart_receiver
    import hexuart_pkg::*;
#(
    parameter int CLKFREQ   = 50000000,
    parameter int BAUDRATE  = 115200,
    parameter int SAMPLECLK = CLKFREQ / BAUDRATE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic [7:0]  prefix,
    output logic [31:0] value,
    output logic        newval,
    output logic        err
);

    logic [7:0]   rx_byte;
    logic         byte_valid;
    logic         frame_err;
    logic [4:0]   dig;
    parse_state_t state;
    logic [7:0]   cand;
    logic [31:0]  shift;
    logic [2:0]   cnt;

    hexuart_deserializer #(
        .SAMPLECLK(SAMPLECLK)
    ) u_deser (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign dig = hex_decode(rx_byte);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_PREFIX;
            cand   <= '0;
            shift  <= '0;
            cnt    <= '0;
            prefix <= '0;
            value  <= '0;
            newval <= 1'b0;
            err    <= 1'b0;
        end else begin
            newval <= 1'b0;
            err    <= 1'b0;
            if (frame_err) begin
                err   <= 1'b1;
                state <= S_PREFIX;
            end else if (byte_valid) begin
                unique case (state)
                    S_PREFIX: begin
                        if (rx_byte != CH_LF && rx_byte != CH_CR) begin
                            cand  <= rx_byte;
                            cnt   <= '0;
                            shift <= '0;
                            state <= S_HEX;
                        end
                    end
                    S_HEX: begin
                        if (dig[4]) begin
                            shift <= {shift[27:0], dig[3:0]};
                            // Counter saturates at the last digit.
                            if (cnt == 3'(HEX_DIGITS - 1))
                                state <= S_LF;
                            else
                                cnt <= cnt + 1'b1;
                        end else begin
                            err   <= 1'b1;
                            state <= S_PREFIX;
                        end
                    end
                    S_LF: begin
                        if (rx_byte == CH_LF) begin
                            state <= S_CR;
                        end else begin
                            err   <= 1'b1;
                            state <= S_PREFIX;
                        end
                    end
                    S_CR: begin
                        state <= S_PREFIX;
                        if (rx_byte == CH_CR) begin
                            prefix <= cand;
                            value  <= shift;
                            newval <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hexuart_receiver.sv
// Randomized + directed bench for hexuart_receiver against a byte-stream line model.
// Build with +define+HEXUART_RX_LOWERCASE_EN to cover the lowercase variant.
module tb_hexuart_receiver;

    localparam int BIT = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx;
    logic [7:0]  prefix;
    logic [31:0] value;
    logic        newval;
    logic        err;

    hexuart_receiver #(
        .CLKFREQ (1600000),
        .BAUDRATE(100000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .rx     (rx),
        .prefix (prefix),
        .value  (value),
        .newval (newval),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [7:0]  p;
        logic [31:0] v;
    } ev_t;

    ev_t         expq[$];
    logic [7:0]  lbuf[$];
    logic [7:0]  hp;
    logic [31:0] hv;
    int          passed = 0;
    int          total  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit hexval(input logic [7:0] c, output logic [3:0] n);
        n = 4'd0;
        if (c >= "0" && c <= "9") begin
            n = 4'(c - 8'h30);
            return 1'b1;
        end
        if (c >= "A" && c <= "F") begin
            n = 4'(c - 8'h41 + 8'd10);
            return 1'b1;
        end
`ifdef HEXUART_RX_LOWERCASE_EN
        if (c >= "a" && c <= "f") begin
            n = 4'(c - 8'h61 + 8'd10);
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    // Line model: the buffer holds the line accepted so far; each byte must
    // fit its position or the line is dropped with an error.
    task automatic model_byte(input logic [7:0] b);
        ev_t         e;
        int          pos;
        bit          ok;
        logic [3:0]  n;
        logic [31:0] v;
        if (lbuf.size() == 0) begin
            if (b != 8'h0A && b != 8'h0D)
                lbuf.push_back(b);
            return;
        end
        pos = lbuf.size();
        if (pos <= 8)
            ok = hexval(b, n);
        else if (pos == 9)
            ok = (b == 8'h0A);
        else
            ok = (b == 8'h0D);
        if (!ok) begin
            e.is_err = 1'b1; e.p = '0; e.v = '0;
            expq.push_back(e);
            lbuf.delete();
            return;
        end
        lbuf.push_back(b);
        if (pos == 10) begin
            v = 0;
            for (int i = 1; i <= 8; i++) begin
                void'(hexval(lbuf[i], n));
                v = v * 16 + 32'(n);
            end
            e.is_err = 1'b0; e.p = lbuf[0]; e.v = v;
            expq.push_back(e);
            lbuf.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        if (stop_ok) begin
            model_byte(b);
        end else begin
            e.is_err = 1'b1; e.p = '0; e.v = '0;
            expq.push_back(e);
            lbuf.delete();
        end
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (BIT) @(posedge clk);
        end else begin
            rx = 1'b0;
            repeat (12) @(posedge clk);
            rx = 1'b1;
            repeat (2 * BIT) @(posedge clk);
        end
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (expq.size() != 0 && k < 20 * BIT) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        chk("drain", 64'(expq.size()), 64'd0);
    endtask

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        ev_t e;
        if (reset_n) begin
            if (newval && err) begin
                chk("both_pulses", 64'(1), 64'(0));
            end else if (newval || err) begin
                if (expq.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, newval, err}, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("pulse_kind", 64'(err), 64'(e.is_err));
                    if (newval && !e.is_err) begin
                        chk("commit_prefix", 64'(prefix), 64'(e.p));
                        chk("commit_value", 64'(value), 64'(e.v));
                        hp = e.p;
                        hv = e.v;
                    end
                end
            end else begin
                chk("held_prefix", 64'(prefix), 64'(hp));
                chk("held_value", 64'(value), 64'(hv));
            end
        end
    end

    initial begin
        string       hx;
        string       s;
        logic [7:0]  c;
        hx = "0123456789ABCDEF";
        hp = '0;
        hv = '0;
        rx = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prefix", 64'(prefix), 64'd0);
        chk("rst_value", 64'(value), 64'd0);
        chk("rst_pulses", {62'd0, newval, err}, 64'd0);
        @(posedge clk);
        reset_n = 1'b1;
        repeat (2 * BIT) @(posedge clk);

        send_line("d0FFF0001\n\r");
        drain();
        chk("t1_prefix", 64'(prefix), 64'h64);
        chk("t1_value", 64'(value), 64'h0fff0001);

        send_line("i80000000\n\rdDEADBEEF\n\r");
        drain();
        chk("t2_prefix", 64'(prefix), 64'h64);
        chk("t2_value", 64'(value), 64'hDEADBEEF);

        send_line("d12G45678\n\rd00000480\n\r");
        drain();
        chk("t3_value", 64'(value), 64'h00000480);

        send_line("d12");
        send_byte("3", 1'b0);
        drain();
        chk("t4_held", 64'(value), 64'h00000480);
        send_line("d00000100\n\r");
        drain();
        chk("t4_value", 64'(value), 64'h00000100);

        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(posedge clk);
        drain();

        send_line("d12");
        rx = 1'b0;
        repeat (BIT + 5) @(posedge clk);
        reset_n = 1'b0;
        lbuf.delete();
        hp = '0;
        hv = '0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        @(negedge clk);
        chk("t5_rst_value", 64'(value), 64'd0);
        chk("t5_rst_prefix", 64'(prefix), 64'd0);
        @(posedge clk);
        reset_n = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        send_line("i12345678\n\r");
        drain();
        chk("t5_prefix", 64'(prefix), 64'h69);
        chk("t5_value", 64'(value), 64'h12345678);

        send_line("dabcdef01\n\r");
        drain();
`ifdef HEXUART_RX_LOWERCASE_EN
        chk("t6_value", 64'(value), 64'hABCDEF01);
`else
        chk("t6_value", 64'(value), 64'h12345678);
`endif

        for (int n = 0; n < 12; n++) begin
            int bad;
            int fpos;
            s = "";
            do c = 8'($urandom_range(0, 255));
            while (c == 8'h0A || c == 8'h0D);
            s = {s, string'(c)};
            for (int i = 0; i < 8; i++)
                s = {s, string'(hx[$urandom_range(0, 15)])};
            s = {s, "\n\r"};
            if ($urandom_range(0, 3) == 0) begin
                bad = $urandom_range(0, 10);
                s[bad] = 8'($urandom_range(0, 255));
            end
            fpos = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : -1;
            for (int i = 0; i < s.len(); i++)
                send_byte(s[i], i != fpos);
            drain();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
